free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameter PR_NUM, default 64, number of physical registers.
REQ-002 Parameter AR_NUM, default 32, number of architectural registers; list depth D = PR_NUM-AR_NUM (default 32).
REQ-003 Parameter PR_W, default 6, physical tag width, equal to clog2(PR_NUM).
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 dispatch_num  input  2  number of tags dispatch consumes this cycle (0..3).
REQ-007 retire_valid  input  3  slot i is retiring an instruction with a destination.
REQ-008 retire_told  input  3xPR_W  Told of retiring slot i, to be freed.
REQ-009 BPRecoverEN  input  1  retire-time misprediction recovery.
REQ-010 free_pr  output  3xPR_W  tags offered to dispatch, in program order.
REQ-011 free_valid  output  3  free_valid[k] = (free_count > k).
REQ-012 free_count  output  PR_W+1  number of free tags (0..D).
REQ-013 fl_error  output  1  sticky protocol-violation flag; present in all builds.

Function
REQ-014 Storage SHALL be a D-entry circular buffer of tags with head, tail (log2 D bits, wrapping modulo D) and count (0..D).
REQ-015 free_pr[k] SHALL be entry[head+k mod D], combinational from registered state; zero-cycle preview, no request handshake.
REQ-016 Allocation SHALL take n = min(dispatch_num, count) tags: head += n, count -= n.
REQ-017 Retire SHALL compact valid slots in slot order 0..2, writing the j-th valid Told to entry[tail+j]; tail += popcount(retire_valid).
REQ-018 Same-cycle allocate and retire: count_next = count + retired - n; tags freed this cycle are not offered to dispatch until the next cycle (no bypass).
REQ-019 Wrap-around: head, tail and write indices SHALL wrap from D-1 to 0 with no bubble.
REQ-020 Full (count = D) with head = tail is a legal state; empty (count = 0) SHALL drive free_valid = 000.
REQ-021 BPRecoverEN SHALL, in the same edge, first apply that cycle's retire writes and tail advance, then set head := new tail and count := D; dispatch_num SHALL be ignored in that cycle.
REQ-022 Recovery SHALL be correct because allocated slots hold exactly the in-flight Tnews in program order.
REQ-023 dispatch_num > count is a violation, and so is count + retired - n > D; either sets fl_error (see REQ-026).

Reset
REQ-024 On reset low: entry[i] = AR_NUM+i for all i; head = tail = 0; count = D; fl_error = 0.
REQ-025 Outputs after reset (defaults): free_pr = {34,33,32} (slots 2..0), free_valid = 111, free_count = 32; reset mid-operation SHALL discard all state immediately, asynchronously.

Configuration
REQ-026 Macro FREELIST_CHECK_EN defined: fl_error SHALL set on any REQ-023 violation and hold until reset, and allocation stays clamped.
REQ-027 Macro FREELIST_CHECK_EN undefined: fl_error SHALL be tied 0, no check logic is built, and clamping remains.

Structure
REQ-028 PR_NUM, AR_NUM and PR_W SHALL come from the shared sys_defs package/header; the module exposes them as parameters defaulting to those constants.
REQ-029 One sub-module, retire_compact, SHALL compute per-slot write offsets and the popcount for retire_valid.

Verification
REQ-030 Reset then dispatch_num=3 -> next cycle free_pr = {37,36,35}, free_count = 29.
REQ-031 Drain 32 tags (11 cycles of 3/3/../2) -> free_count = 0, free_valid = 000; retire_valid=001, told=7 -> next cycle free_pr[0] = 7, free_count = 1.
REQ-032 Same cycle: dispatch_num=2 with retire_valid=101 (told 40, 41) -> free_count unchanged; 40 and 41 written at tail, tail +2.
REQ-033 Allocate 10; retire 4 (told 1..4); BPRecoverEN with retire_valid=001 told 5 -> free_count = 32, head = tail = 5, free_pr[0] = entry that held the 6th allocated tag (37).
REQ-034 Run 40 cycles of allocate-3/retire-3 -> head/tail wrap past 31 with no tag lost or duplicated; a scoreboard of all PR_NUM tags stays consistent.
REQ-035 With FREELIST_CHECK_EN: count=1, dispatch_num=3 -> 1 tag taken, count=0, fl_error=1 and sticky; without the macro -> fl_error=0.

Source files
------------

// File: rtl/sys_defs.sv
// sys_defs: shared machine-configuration constants for the rename/retire
// slice of the core.
//   SYS_PR_NUM : number of physical registers
//   SYS_AR_NUM : number of architectural registers
//   SYS_PR_W   : physical tag width, clog2(SYS_PR_NUM)
//   RET_SLOTS  : dispatch/retire slots per cycle
package sys_defs;

    localparam int SYS_PR_NUM = 64;
    localparam int SYS_AR_NUM = 32;
    localparam int SYS_PR_W   = 6;
    localparam int RET_SLOTS  = 3;

endpackage

// File: rtl/retire_compact.sv
// retire_compact: packs the valid retire slots into consecutive free-list
// write positions.
// Ports:
//   retire_valid [2:0] in  : slot i retires an instruction with a destination
//   slot_off     [5:0] out : 2-bit write offset (from tail) for each slot;
//                            only meaningful where retire_valid is set
//   ret_cnt      [1:0] out : popcount of retire_valid
module retire_compact
    import sys_defs::*;
(
    input  logic [2:0] retire_valid,
    output logic [5:0] slot_off,
    output logic [1:0] ret_cnt
);

    // Running prefix count: a slot's offset is the number of valid slots
    // before it, so slots 0..2 land in order with no gaps.
    always_comb begin
        ret_cnt  = '0;
        slot_off = '0;
        for (int unsigned i = 0; i < RET_SLOTS; i++) begin
            slot_off[2*i +: 2] = ret_cnt;
            ret_cnt            = ret_cnt + {1'b0, retire_valid[i]};
        end
    end

endmodule

// File: rtl/free_list.sv
// free_list: circular free list of physical register tags for a 3-wide
// rename stage, with retire-time branch-misprediction recovery.
// Ports:
//   clock            in  : rising-edge clock
//   reset            in  : asynchronous, active-low reset
//   dispatch_num [1:0]   in  : tags consumed by dispatch this cycle (0..3)
//   retire_valid [2:0]   in  : retiring slot i frees its Told
//   retire_told  [3*PR_W-1:0] in : Told per retire slot
//   BPRecoverEN      in  : recovery; free list becomes full again
//   free_pr [3*PR_W-1:0] out : next three free tags, slot 0 oldest
//   free_valid [2:0]     out : free_valid[k] = free_count > k
//   free_count [PR_W:0]  out : number of free tags
//   fl_error         out : sticky protocol-violation flag
// Build option: define FREELIST_CHECK_EN to build the violation checker;
// otherwise fl_error is tied low.
module free_list
    import sys_defs::*;
#(
    parameter int PR_NUM = SYS_PR_NUM,
    parameter int AR_NUM = SYS_AR_NUM,
    parameter int PR_W   = SYS_PR_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          dispatch_num,
    input  logic [2:0]          retire_valid,
    input  logic [3*PR_W-1:0]   retire_told,
    input  logic                BPRecoverEN,
    output logic [3*PR_W-1:0]   free_pr,
    output logic [2:0]          free_valid,
    output logic [PR_W:0]       free_count,
    output logic                fl_error
);

    localparam int D  = PR_NUM - AR_NUM;
    localparam int IW = $clog2(D);
    localparam int CW = PR_W + 1;
    localparam logic [CW-1:0] D_CNT = CW'(D);

    logic [PR_W-1:0] entry [D];
    logic [IW-1:0]   head;
    logic [IW-1:0]   tail;
    logic [CW-1:0]   count;

    logic [5:0]      slot_off;
    logic [1:0]      ret_cnt;
    logic [1:0]      alloc_n;
    logic [CW:0]     count_sum;
    logic            over_full;
    logic [IW-1:0]   tail_next;
    logic [IW-1:0]   wr_idx [3];

    // Index addition modulo D; correct for non-power-of-two depths too.
    function automatic logic [IW-1:0] idx_add(input logic [IW-1:0] base,
                                              input logic [1:0]    off);
        logic [IW:0] sum;
        sum = {1'b0, base} + (IW+1)'(off);
        if (sum >= (IW+1)'(D))
            sum = sum - (IW+1)'(D);
        return sum[IW-1:0];
    endfunction

    retire_compact u_retire_compact (
        .retire_valid (retire_valid),
        .slot_off     (slot_off),
        .ret_cnt      (ret_cnt)
    );

    always_comb begin
        free_pr    = '0;
        free_valid = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            free_pr[k*PR_W +: PR_W] = entry[idx_add(head, 2'(k))];
            free_valid[k]           = count > CW'(k);
        end
    end

    assign free_count = count;

    always_comb begin
        // Allocation is clamped to what is present; count < dispatch_num <= 3
        // guarantees count fits in two bits on the clamped path.
        alloc_n = (CW'(dispatch_num) > count) ? count[1:0] : dispatch_num;
        if (BPRecoverEN)
            alloc_n = '0;
        count_sum = (CW+1)'(count) + (CW+1)'(ret_cnt) - (CW+1)'(alloc_n);
        over_full = count_sum > (CW+1)'(D);
        tail_next = idx_add(tail, ret_cnt);
        for (int unsigned i = 0; i < 3; i++)
            wr_idx[i] = idx_add(tail, slot_off[2*i +: 2]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= D_CNT;
            for (int unsigned i = 0; i < D; i++)
                entry[i] <= PR_W'(AR_NUM + i);
        end else begin
            for (int unsigned i = 0; i < 3; i++)
                if (retire_valid[i])
                    entry[wr_idx[i]] <= retire_told[i*PR_W +: PR_W];
            tail <= tail_next;
            if (BPRecoverEN) begin
                // Slots between the new tail and the old head still hold the
                // in-flight Tnews in program order, so the whole ring is free.
                head  <= tail_next;
                count <= D_CNT;
            end else begin
                head  <= idx_add(head, alloc_n);
                // An over-retire is a protocol violation; saturate to keep
                // the count within the ring.
                count <= over_full ? D_CNT : count_sum[CW-1:0];
            end
        end
    end

`ifdef FREELIST_CHECK_EN
    logic err_q;
    logic violation;

    assign violation = !BPRecoverEN &&
                       ((CW'(dispatch_num) > count) || over_full);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            err_q <= 1'b0;
        else if (violation)
            err_q <= 1'b1;
    end

    assign fl_error = err_q;
`else
    assign fl_error = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;
    import sys_defs::*;

    localparam int PW = SYS_PR_W;
    localparam int AR = SYS_AR_NUM;
    localparam int D  = SYS_PR_NUM - SYS_AR_NUM;
`ifdef FREELIST_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        dispatch_num = '0;
    logic [2:0]        retire_valid = '0;
    logic [3*PW-1:0]   retire_told = '0;
    logic              BPRecoverEN = 1'b0;
    logic [3*PW-1:0]   free_pr;
    logic [2:0]        free_valid;
    logic [PW:0]       free_count;
    logic              fl_error;

    free_list #(.PR_NUM(SYS_PR_NUM), .AR_NUM(SYS_AR_NUM), .PR_W(SYS_PR_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .dispatch_num (dispatch_num),
        .retire_valid (retire_valid),
        .retire_told  (retire_told),
        .BPRecoverEN  (BPRecoverEN),
        .free_pr      (free_pr),
        .free_valid   (free_valid),
        .free_count   (free_count),
        .fl_error     (fl_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int              cyc;
        string           name;
        logic [3*PW-1:0] pr;
        logic [2:0]      prm;
        logic            chk_v;
        logic [2:0]      valid;
        logic            chk_c;
        logic [PW:0]     cnt;
        logic            chk_e;
        logic            err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: fq = free tags in offer order, aq = allocated ring
    // slots not yet overwritten by retire (oldest first), held = tags
    // currently owned by the pipeline (architectural + in flight).
    int   fq[$];
    int   aq[$];
    int   held[$];
    logic merr;

    function automatic logic [3*PW-1:0] pk(int s0, int s1, int s2);
        return {PW'(s2), PW'(s1), PW'(s0)};
    endfunction

    function void model_reset();
        fq.delete();
        aq.delete();
        held.delete();
        for (int i = 0; i < D; i++) fq.push_back(AR + i);
        for (int i = 0; i < AR; i++) held.push_back(i);
        merr = 1'b0;
    endfunction

    function void push_model(int at);
        exp_t e;
        e.cyc  = at;
        e.name = "model";
        e.pr   = '0;
        for (int k = 0; k < 3; k++) begin
            e.prm[k]   = (k < fq.size());
            e.valid[k] = (k < fq.size());
            if (k < fq.size()) e.pr[k*PW +: PW] = PW'(fq[k]);
        end
        e.chk_v = 1'b1;
        e.chk_c = 1'b1;
        e.cnt   = (PW+1)'(fq.size());
        e.chk_e = 1'b1;
        e.err   = merr;
        sb.push_back(e);
    endfunction

    function void model_update(int disp, logic [2:0] rv, int t0, int t1, int t2, logic rec);
        int n;
        int t[3];
        int x;
        t = '{t0, t1, t2};
        n = rec ? 0 : ((disp < fq.size()) ? disp : fq.size());
        if (EXP_ERR && !rec && disp > fq.size()) merr = 1'b1;
        for (int i = 0; i < n; i++) begin
            x = fq.pop_front();
            aq.push_back(x);
            held.push_back(x);
        end
        for (int i = 0; i < 3; i++)
            if (rv[i]) begin
                if (aq.size() > 0) void'(aq.pop_front());
                fq.push_back(t[i]);
            end
        if (rec) begin
            fq = {aq, fq};
            aq.delete();
        end
    endfunction

    task automatic hand(string nm, int off, logic [3*PW-1:0] pr, logic [2:0] prm,
                        logic chk_v, logic [2:0] v, logic chk_c, int c,
                        logic chk_e, logic e);
        exp_t x;
        x.cyc = cyc + off; x.name = nm; x.pr = pr; x.prm = prm;
        x.chk_v = chk_v; x.valid = v; x.chk_c = chk_c; x.cnt = (PW+1)'(c);
        x.chk_e = chk_e; x.err = e;
        sb.push_back(x);
    endtask

    task automatic step(int disp, logic [2:0] rv, int t0, int t1, int t2, logic rec);
        @(posedge clock); #1;
        push_model(cyc);
        dispatch_num = 2'(disp);
        retire_valid = rv;
        retire_told  = pk(t0, t1, t2);
        BPRecoverEN  = rec;
        model_update(disp, rv, t0, t1, t2, rec);
    endtask

    task automatic idle();
        step(0, 3'b000, 0, 0, 0, 1'b0);
    endtask

    task automatic alloc(int n);
        int k;
        while (n > 0) begin
            k = (n > 3) ? 3 : n;
            step(k, 3'b000, 0, 0, 0, 1'b0);
            n -= k;
        end
    endtask

    task automatic zero_inputs();
        dispatch_num = '0; retire_valid = '0; retire_told = '0; BPRecoverEN = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        zero_inputs();
        model_reset();
        push_model(cyc);
        @(posedge clock); #1;
        push_model(cyc);
        reset = 1'b1;
    endtask

    // Monitor: compares every expectation due at this cycle.
    always @(negedge clock) begin
        exp_t e;
        logic ok;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e  = sb.pop_front();
            ok = (e.cyc == cyc);
            for (int k = 0; k < 3; k++)
                if (e.prm[k] && free_pr[k*PW +: PW] !== e.pr[k*PW +: PW]) ok = 1'b0;
            if (e.chk_v && free_valid !== e.valid) ok = 1'b0;
            if (e.chk_c && free_count !== e.cnt) ok = 1'b0;
            if (e.chk_e && fl_error !== e.err) ok = 1'b0;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL %s cyc=%0d/%0d: got pr=%h valid=%b cnt=%0d err=%b, want pr=%h (slots %b) valid=%b cnt=%0d err=%b",
                         e.name, cyc, e.cyc, free_pr, free_valid, free_count, fl_error,
                         e.pr, e.prm, e.valid, e.cnt, e.err);
            end
        end
    end

    initial begin
        int t0, t1, t2;
        model_reset();

        do_reset();
        hand("reset_out", 0, pk(32, 33, 34), 3'b111, 1, 3'b111, 1, 32, 1, 1'b0);
        step(3, 3'b000, 0, 0, 0, 1'b0);
        hand("alloc3", 1, pk(35, 36, 37), 3'b111, 1, 3'b111, 1, 29, 0, 1'b0);
        idle();

        do_reset();
        alloc(32);
        hand("drained", 1, '0, 3'b000, 1, 3'b000, 1, 0, 1, 1'b0);
        step(0, 3'b001, 7, 0, 0, 1'b0);
        hand("refill7", 1, pk(7, 0, 0), 3'b001, 1, 3'b001, 1, 1, 0, 1'b0);
        idle();

        do_reset();
        alloc(10);
        step(2, 3'b101, 40, 55, 41, 1'b0);
        hand("same_cycle", 1, '0, 3'b000, 0, 3'b000, 1, 22, 0, 1'b0);
        alloc(18);
        hand("tail_write", 1, pk(62, 63, 40), 3'b111, 1, 3'b111, 1, 4, 0, 1'b0);
        alloc(3);
        hand("tail_write2", 1, pk(41, 0, 0), 3'b001, 1, 3'b001, 1, 1, 0, 1'b0);
        idle();

        do_reset();
        alloc(10);
        step(0, 3'b111, 1, 2, 3, 1'b0);
        step(0, 3'b001, 4, 0, 0, 1'b0);
        step(3, 3'b001, 5, 0, 0, 1'b1);
        hand("recover", 1, pk(37, 38, 39), 3'b111, 1, 3'b111, 1, 32, 0, 1'b0);
        alloc(27);
        hand("post_recover", 1, pk(1, 2, 3), 3'b111, 1, 3'b111, 1, 5, 0, 1'b0);
        idle();

        do_reset();
        alloc(6);
        for (int i = 0; i < 40; i++) begin
            t0 = held.pop_front();
            t1 = held.pop_front();
            t2 = held.pop_front();
            step(3, 3'b111, t0, t1, t2, 1'b0);
        end
        hand("wrap_count", 1, '0, 3'b000, 1, 3'b111, 1, 26, 1, 1'b0);
        idle();

        do_reset();
        alloc(31);
        step(3, 3'b000, 0, 0, 0, 1'b0);
        hand("clamp", 1, '0, 3'b000, 1, 3'b000, 1, 0, 1, EXP_ERR);
        idle();
        hand("sticky", 1, '0, 3'b000, 1, 3'b000, 1, 0, 1, EXP_ERR);
        step(0, 3'b001, 9, 0, 0, 1'b0);
        hand("sticky2", 1, pk(9, 0, 0), 3'b001, 1, 3'b001, 1, 1, 1, EXP_ERR);
        idle();

        // Reset asserted between edges must take effect before any clock.
        @(posedge clock); #2;
        reset = 1'b0;
        zero_inputs();
        model_reset();
        hand("async_reset", 0, pk(32, 33, 34), 3'b111, 1, 3'b111, 1, 32, 1, 1'b0);
        @(posedge clock); #1;
        reset = 1'b1;
        step(3, 3'b000, 0, 0, 0, 1'b0);
        hand("after_reset", 1, pk(35, 36, 37), 3'b111, 1, 3'b111, 1, 29, 1, 1'b0);
        idle();
        idle();

        repeat (3) @(posedge clock);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
